// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the main-memory front-end controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 4;
  localparam int unsigned WR_PULSE_DEF = 2;
  localparam int unsigned RD_CYC_DEF   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WPULSE,
    WHOLD,
    RD,
    ACK
  } state_e;

  typedef enum logic [1:0] {
    G_CPU,
    G_MAN,
    G_CLR
  } grant_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to whichever side was not acked last.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_cpu_i,
  input  logic req_man_i,
  input  logic adv_i,
  input  logic adv_man_i,
  output logic gnt_cpu_o,
  output logic gnt_man_o
);

  logic last_man_q;

  // Remembers who completed last; reset marks CPU as last so the first tie goes to manual.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_man_q <= 1'b0;
    end else if (adv_i) begin
      last_man_q <= adv_man_i;
    end
  end

  // Grant choice is combinational; the sequencer samples it only in IDLE.
  always_comb begin
    gnt_man_o = req_man_i & (~req_cpu_i | ~last_man_q);
    gnt_cpu_o = req_cpu_i & ~gnt_man_o;
  end

endmodule

// File: rtl/ram_access_sequencer.sv
// Sequences CPU, manual-panel and bulk-clear accesses onto the 256x4 main memory
// with setup/pulse/hold write framing and registered memory controls.
module ram_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned WR_PULSE_CYC = WR_PULSE_DEF,
  parameter int unsigned RD_CYC       = RD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              man_req,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_data,
  output logic              man_ack,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_w_enable,
  output logic              mem_r_enable,
  output logic              mem_manual_mode,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_MAX = (WR_PULSE_CYC > RD_CYC) ? WR_PULSE_CYC : RD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  grant_src_e        src_q, src_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_armed_q, clr_armed_d;

  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              man_ack_q, man_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              mman_q, mman_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              moe_q, moe_d;

  logic gnt_cpu_c, gnt_man_c, adv_c;

  assign adv_c = (state_q == ACK) && (src_q != G_CLR);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_cpu_i (cpu_req),
    .req_man_i (man_req),
    .adv_i     (adv_c),
    .adv_man_i (src_q == G_MAN),
    .gnt_cpu_o (gnt_cpu_c),
    .gnt_man_o (gnt_man_c)
  );

  // Next-state and next-output logic; every memory control is computed for the coming cycle.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pcnt_d      = pcnt_q;
    clr_cnt_d   = clr_cnt_q;
    clr_armed_d = clr_armed_q | ~clr_req;
    cpu_ack_d   = 1'b0;
    man_ack_d   = 1'b0;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    maddr_d     = maddr_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    mman_d      = mman_q;
    mwdata_d    = mwdata_q;
    moe_d       = moe_q;

    unique case (state_q)
      IDLE: begin
        mman_d   = 1'b0;
        moe_d    = 1'b0;
        mwdata_d = '0;
        if (clr_req && clr_armed_q) begin
          src_d       = G_CLR;
          we_d        = 1'b1;
          addr_d      = '0;
          data_d      = '0;
          clr_cnt_d   = '0;
          clr_armed_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = SETUP;
        end else if (gnt_cpu_c) begin
          src_d   = G_CPU;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          data_d  = cpu_wdata;
          state_d = SETUP;
        end else if (gnt_man_c) begin
          src_d   = G_MAN;
          we_d    = 1'b1;
          addr_d  = man_addr;
          data_d  = man_data;
          state_d = SETUP;
        end
        if (state_d == SETUP) begin
          maddr_d  = addr_d;
          moe_d    = we_d;
          mwdata_d = we_d ? data_d : '0;
          mman_d   = (src_d == G_MAN);
        end
      end
      SETUP: begin
        pcnt_d = '0;
        if (we_q) begin
          wen_d   = 1'b1;
          state_d = WPULSE;
        end else begin
          ren_d   = 1'b1;
          state_d = RD;
        end
      end
      WPULSE: begin
        if (pcnt_q == CNT_W'(WR_PULSE_CYC - 1)) begin
          state_d = WHOLD;
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
          wen_d  = 1'b1;
        end
      end
      WHOLD: begin
        state_d  = ACK;
        moe_d    = 1'b0;
        mwdata_d = '0;
        if (src_q == G_CLR) begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end else if (src_q == G_CPU) begin
          cpu_ack_d = 1'b1;
        end else begin
          man_ack_d = 1'b1;
        end
      end
      RD: begin
        if (pcnt_q == CNT_W'(RD_CYC - 1)) begin
          state_d   = ACK;
          rdata_d   = mem_rdata;
          cpu_ack_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
          ren_d  = 1'b1;
        end
      end
      ACK: begin
        // A wrapped clear counter marks the end of the sweep.
        if ((src_q == G_CLR) && (clr_cnt_q != '0)) begin
          addr_d   = clr_cnt_q;
          maddr_d  = clr_cnt_q;
          moe_d    = 1'b1;
          mwdata_d = '0;
          state_d  = SETUP;
        end else begin
          mman_d  = 1'b0;
          state_d = IDLE;
          if (src_q == G_CLR) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= G_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pcnt_q      <= '0;
      clr_cnt_q   <= '0;
      clr_armed_q <= 1'b1;
      cpu_ack_q   <= 1'b0;
      rdata_q     <= '0;
      man_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      maddr_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      mman_q      <= 1'b0;
      mwdata_q    <= '0;
      moe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pcnt_q      <= pcnt_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_armed_q <= clr_armed_d;
      cpu_ack_q   <= cpu_ack_d;
      rdata_q     <= rdata_d;
      man_ack_q   <= man_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      maddr_q     <= maddr_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      mman_q      <= mman_d;
      mwdata_q    <= mwdata_d;
      moe_q       <= moe_d;
    end
  end

  assign cpu_ack         = cpu_ack_q;
  assign cpu_rdata       = rdata_q;
  assign man_ack         = man_ack_q;
  assign clr_busy        = busy_q;
  assign clr_done        = done_q;
  assign mem_address     = maddr_q;
  assign mem_w_enable    = wen_q;
  assign mem_r_enable    = ren_q;
  assign mem_manual_mode = mman_q;
  assign mem_wdata       = mwdata_q;
  assign mem_wdata_oe    = moe_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed and randomized bench for ram_access_sequencer against a memory-image reference model.
module tb_ram_access_sequencer;

  localparam int AW  = 8;
  localparam int DW  = 4;
  localparam int WRP = 2;
  localparam int RDC = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          man_req, man_ack;
  logic [AW-1:0] man_addr;
  logic [DW-1:0] man_data;
  logic          clr_req, clr_busy, clr_done;
  logic [AW-1:0] mem_address;
  logic          mem_w_enable, mem_r_enable, mem_manual_mode, mem_wdata_oe;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int mon_viol = 0;

  logic [DW-1:0] env_mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] last_rd;

  always #5 clk = ~clk;

  ram_access_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .WR_PULSE_CYC(WRP), .RD_CYC(RDC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .man_req(man_req), .man_addr(man_addr), .man_data(man_data), .man_ack(man_ack),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_address(mem_address), .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
    .mem_manual_mode(mem_manual_mode), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata)
  );

  // Memory stand-in: captures on the rising edge of the write strobe.
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = '0;
    forever begin
      @(posedge mem_w_enable);
      if (mem_wdata_oe) env_mem[mem_address] = mem_wdata;
    end
  end

  assign mem_rdata = mem_r_enable ? env_mem[mem_address] : '0;

  // Bus invariants sampled mid-cycle.
  logic          p_wen = 1'b0, p_oe = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_wdata_oe && mem_r_enable) mon_viol++;
      if (cpu_ack && man_ack) mon_viol++;
      if (mem_w_enable && !p_wen &&
          !(p_oe && mem_wdata_oe && p_addr == mem_address && p_wdata == mem_wdata)) mon_viol++;
    end
    p_wen   = mem_w_enable;
    p_oe    = mem_wdata_oe;
    p_addr  = mem_address;
    p_wdata = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a requester, checked against the spec's timing rules.
  task automatic do_op(input bit is_man, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input bit mutate);
    int n, wcyc, rcyc, first_w, lat;
    bit got, mm_bad, wrong;
    lat = we ? 3 + WRP : 2 + RDC;
    if (is_man) begin
      man_addr = addr; man_data = data; man_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
    end
    n = 0; wcyc = 0; rcyc = 0; first_w = 0; got = 1'b0; mm_bad = 1'b0; wrong = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (mutate && n == 1) begin
        cpu_addr = addr ^ 8'h30; cpu_wdata = ~data; cpu_req = 1'b0;
      end
      if (mem_w_enable) begin
        wcyc++;
        if (first_w == 0) first_w = n;
      end
      if (mem_r_enable) rcyc++;
      if (n < lat && mem_manual_mode !== is_man) mm_bad = 1'b1;
      if (is_man ? cpu_ack : man_ack) wrong = 1'b1;
      got = is_man ? man_ack : cpu_ack;
    end
    chk("ack_seen", 32'(got), 32'(1));
    chk("ack_latency", 32'(n), 32'(lat));
    chk("ack_to_other", 32'(wrong), 32'(0));
    chk("wen_cycles", 32'(wcyc), 32'(we ? WRP : 0));
    chk("ren_cycles", 32'(rcyc), 32'(we ? 0 : RDC));
    chk("manual_mode", 32'(mm_bad), 32'(0));
    if (we) begin
      chk("wen_start", 32'(first_w), 32'(2));
      chk("rdata_hold", 32'(cpu_rdata), 32'(last_rd));
      exp_mem[addr] = data;
    end else begin
      chk("rdata", 32'(cpu_rdata), 32'(exp_mem[addr]));
      last_rd = exp_mem[addr];
    end
    cpu_req = 1'b0;
    man_req = 1'b0;
    tick();
    chk("ack_single", 32'(cpu_ack | man_ack), 32'(0));
  endtask

  initial begin
    int n, busycnt, wcyc, extra_done;
    bit got, early;
    logic [AW-1:0] ra;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    man_req = 1'b0; man_addr = '0; man_data = '0; clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    last_rd = '0;
    repeat (3) tick();
    chk("rst_ctrl", 32'({mem_w_enable, mem_r_enable, mem_wdata_oe, mem_manual_mode}), 32'(0));
    chk("rst_acks", 32'({cpu_ack, man_ack, clr_busy, clr_done}), 32'(0));
    chk("rst_addr", 32'(mem_address), 32'(0));
    chk("rst_bus", 32'({cpu_rdata, mem_wdata}), 32'(0));
    rst_n = 1'b1;
    tick();

    // Tie between CPU and manual held for four transactions.
    cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 4'h1; cpu_req = 1'b1;
    man_addr = 8'h80; man_data = 4'h2; man_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bit want_man;
      want_man = (t % 2) == 0;
      n = 0; got = 1'b0;
      while (!got && n < 30) begin
        tick();
        n++;
        got = cpu_ack | man_ack;
      end
      chk("tie_gap", 32'(n), 32'(t == 0 ? 3 + WRP : 4 + WRP));
      chk("tie_man_ack", 32'(man_ack), 32'(want_man));
      chk("tie_cpu_ack", 32'(cpu_ack), 32'(!want_man));
      if (want_man) begin
        exp_mem[man_addr] = man_data; man_addr++; man_data++;
      end else begin
        exp_mem[cpu_addr] = cpu_wdata; cpu_addr++; cpu_wdata++;
      end
    end
    cpu_req = 1'b0; man_req = 1'b0;
    tick();
    do_op(0, 0, 8'h40, 4'h0, 0);
    do_op(0, 0, 8'h41, 4'h0, 0);
    do_op(0, 0, 8'h80, 4'h0, 0);
    do_op(0, 0, 8'h81, 4'h0, 0);

    // Directed CPU write/readback and manual write.
    do_op(0, 1, 8'h3A, 4'h9, 0);
    do_op(0, 0, 8'h3A, 4'h0, 0);
    do_op(1, 1, 8'hFF, 4'h5, 0);
    chk("env_mem_ff", 32'(env_mem[8'hFF]), 32'(5));
    do_op(0, 0, 8'hFF, 4'h0, 0);

    // Inputs change and request drops right after the grant.
    do_op(0, 1, 8'h10, 4'h3, 1);
    do_op(0, 0, 8'h10, 4'h0, 0);
    do_op(0, 0, 8'h20, 4'h0, 0);

    // Randomized mix against the reference memory image.
    for (int k = 0; k < 40; k++) begin
      bit m, w;
      m = 1'($urandom_range(0, 1));
      w = m ? 1'b1 : 1'($urandom_range(0, 1));
      do_op(m, w, AW'($urandom_range(0, 15)), DW'($urandom), 0);
    end

    // Reset during the write pulse aborts without an ack.
    cpu_we = 1'b1; cpu_addr = 8'h55; cpu_wdata = 4'h6; cpu_req = 1'b1;
    tick(); tick();
    chk("pre_rst_wen", 32'(mem_w_enable), 32'(1));
    exp_mem[8'h55] = 4'h6;
    rst_n = 1'b0;
    tick();
    chk("rst_mid_ctrl", 32'({mem_w_enable, mem_wdata_oe, mem_r_enable}), 32'(0));
    chk("rst_mid_ack", 32'(cpu_ack), 32'(0));
    cpu_req = 1'b0;
    tick();
    chk("rst_mid_ack2", 32'(cpu_ack), 32'(0));
    rst_n = 1'b1;
    last_rd = '0;
    tick();
    chk("post_rst_quiet", 32'({cpu_ack, mem_w_enable, mem_wdata_oe}), 32'(0));
    do_op(0, 1, 8'h66, 4'hC, 0);
    do_op(0, 0, 8'h66, 4'h0, 0);

    // Preload then a one-cycle clear pulse with a CPU read arriving mid-sweep.
    do_op(0, 1, 8'h00, 4'hA, 0);
    do_op(0, 1, 8'h7F, 4'hA, 0);
    do_op(0, 1, 8'hFF, 4'hA, 0);
    do_op(1, 1, 8'h33, 4'hA, 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0; busycnt = 0; wcyc = 0; early = 1'b0;
    while (n < 2000) begin
      if (clr_busy) busycnt++;
      if (mem_w_enable) wcyc++;
      if (cpu_ack) early = 1'b1;
      if (n == 300) begin
        cpu_we = 1'b0; cpu_addr = 8'h7F; cpu_req = 1'b1;
      end
      if (clr_done) break;
      tick();
      n++;
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    chk("clr_done_seen", 32'(clr_done), 32'(1));
    chk("clr_busy_at_done", 32'(clr_busy), 32'(0));
    chk("clr_busy_cycles", 32'(busycnt), 32'(DEPTH * (3 + WRP)));
    chk("clr_wen_cycles", 32'(wcyc), 32'(DEPTH * WRP));
    chk("cpu_served_early", 32'(early), 32'(0));
    n = 0; got = 1'b0; extra_done = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (clr_done) extra_done++;
      got = cpu_ack;
    end
    chk("post_clr_latency", 32'(n), 32'(2 + RDC));
    chk("post_clr_rdata", 32'(cpu_rdata), 32'(0));
    chk("clr_done_once", 32'(extra_done), 32'(0));
    last_rd = '0;
    cpu_req = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i);
      do_op(0, 0, ra, 4'h0, 0);
    end

    // Clear request held high through completion must not re-trigger.
    do_op(0, 1, 8'h12, 4'h7, 0);
    clr_req = 1'b1;
    n = 0;
    while (!clr_done && n < 2000) begin
      tick();
      n++;
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    chk("clr2_done", 32'(clr_done), 32'(1));
    chk("clr2_cycles", 32'(n), 32'(DEPTH * (3 + WRP) + 1));
    tick(); tick();
    chk("clr2_no_retrigger", 32'(clr_busy), 32'(0));
    do_op(0, 1, 8'h12, 4'h4, 0);
    chk("clr2_still_idle", 32'(clr_busy), 32'(0));
    clr_req = 1'b0;
    tick();
    do_op(0, 0, 8'h12, 4'h0, 0);
    do_op(0, 0, 8'h7F, 4'h0, 0);

    chk("bus_invariants", 32'(mon_viol), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
